loop_nest_sequencer: RTL and testbench

Two-level loop-nest sequencer that drives wrap-around index counters through a 2-D iteration space (outer j, inner i) and hands each index pair to a downstream stream consumer under valid/ready flow control. It sits between the kernel control logic (start/abort/done) and the datapath's address/index generators. It replaces free-running counters wherever the iteration space must be bounded, stallable and restartable.

---
 rtl/loop_nest_sequencer.sv | 145 ++++++++++++++
 tb/tb_loop_nest_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loop_nest_sequencer.sv
// Two-level (outer j, inner i) index sequencer with valid/ready output and start/abort/done control.
// Bounds are latched at start; every output comes straight from a flop.
module loop_nest_sequencer #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] cfg_imax,
    input  logic [W-1:0] cfg_jmax,
    input  logic         out_ready,
    output logic [W-1:0] idx_i,
    output logic [W-1:0] idx_j,
    output logic         out_valid,
    output logic         out_last,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [W-1:0] One = W'(1);

    state_e       state_q, state_d;
    logic [W-1:0] idx_i_q, idx_i_d;
    logic [W-1:0] idx_j_q, idx_j_d;
    logic [W-1:0] imax_q, imax_d;
    logic [W-1:0] jmax_q, jmax_d;
    logic         out_valid_q, out_valid_d;
    logic         out_last_q, out_last_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [W-1:0] idx_i_inc;
    logic [W-1:0] idx_j_inc;
    logic         i_at_max;
    logic         j_at_max;

    // Wrap is decided by comparing against the bound, so the increment never carries out.
    assign idx_i_inc = idx_i_q + One;
    assign idx_j_inc = idx_j_q + One;
    assign i_at_max  = (idx_i_q == imax_q);
    assign j_at_max  = (idx_j_q == jmax_q);

    always_comb begin
        state_d     = state_q;
        idx_i_d     = idx_i_q;
        idx_j_d     = idx_j_q;
        imax_d      = imax_q;
        jmax_d      = jmax_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                busy_d      = 1'b0;
                if (start) begin
                    state_d     = StRun;
                    imax_d      = cfg_imax;
                    jmax_d      = cfg_jmax;
                    idx_i_d     = '0;
                    idx_j_d     = '0;
                    out_valid_d = 1'b1;
                    out_last_d  = (cfg_imax == '0) && (cfg_jmax == '0);
                    busy_d      = 1'b1;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d     = StIdle;
                    idx_i_d     = '0;
                    idx_j_d     = '0;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    busy_d      = 1'b0;
                end else if (out_valid_q && out_ready) begin
                    if (!i_at_max) begin
                        idx_i_d    = idx_i_inc;
                        out_last_d = (idx_i_inc == imax_q) && j_at_max;
                    end else if (!j_at_max) begin
                        idx_i_d    = '0;
                        idx_j_d    = idx_j_inc;
                        out_last_d = (imax_q == '0) && (idx_j_inc == jmax_q);
                    end else begin
                        state_d     = StDone;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d     = StIdle;
                idx_i_d     = '0;
                idx_j_d     = '0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                busy_d      = 1'b0;
            end
            default: begin
                state_d     = StIdle;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_i_q     <= '0;
            idx_j_q     <= '0;
            imax_q      <= '0;
            jmax_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_i_q     <= idx_i_d;
            idx_j_q     <= idx_j_d;
            imax_q      <= imax_d;
            jmax_q      <= jmax_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign idx_i     = idx_i_q;
    assign idx_j     = idx_j_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_loop_nest_sequencer.sv
// Directed bench for loop_nest_sequencer: a W=10 instance for most scenarios and a W=4
// instance for the all-ones bound sweep.
module tb_loop_nest_sequencer;

    logic       clk;
    logic       reset;

    logic       start, abort, out_ready;
    logic [9:0] cfg_imax, cfg_jmax;
    logic [9:0] idx_i, idx_j;
    logic       out_valid, out_last, busy, done;

    logic       start4, abort4, ready4;
    logic [3:0] cfg_imax4, cfg_jmax4;
    logic [3:0] idx_i4, idx_j4;
    logic       out_valid4, out_last4, busy4, done4;

    int n_checks;
    int n_errors;

    logic [23:0] obs, expv;
    logic [11:0] obs4, expv4;

    loop_nest_sequencer #(.W(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .cfg_imax (cfg_imax),
        .cfg_jmax (cfg_jmax),
        .out_ready(out_ready),
        .idx_i    (idx_i),
        .idx_j    (idx_j),
        .out_valid(out_valid),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    loop_nest_sequencer #(.W(4)) dut4 (
        .clk      (clk),
        .reset    (reset),
        .start    (start4),
        .abort    (abort4),
        .cfg_imax (cfg_imax4),
        .cfg_jmax (cfg_jmax4),
        .out_ready(ready4),
        .idx_i    (idx_i4),
        .idx_j    (idx_j4),
        .out_valid(out_valid4),
        .out_last (out_last4),
        .busy     (busy4),
        .done     (done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs  = {out_valid, idx_i, idx_j, out_last, busy, done};
    assign obs4 = {out_valid4, idx_i4, idx_j4, out_last4, busy4, done4};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (obs !== 24'h0) begin
            n_errors++;
            $display("FAIL reset_w10 got %h want %h", obs, 24'h0);
        end
        n_checks++;
        if (obs4 !== 12'h0) begin
            n_errors++;
            $display("FAIL reset_w4 got %h want %h", obs4, 12'h0);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        cfg_imax  = 10'd2;
        cfg_jmax  = 10'd1;
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            expv = {1'b1, 10'(k % 3), 10'(k / 3), (k == 5), 1'b1, 1'b0};
            n_checks++;
            if (obs !== expv) begin
                n_errors++;
                $display("FAIL basic_pair%0d got %h want %h", k, obs, expv);
            end
            tick();
        end
        n_checks++;
        if ({out_valid, out_last, busy, done} !== 4'b0011) begin
            n_errors++;
            $display("FAIL basic_done got %b want 0011", {out_valid, out_last, busy, done});
        end
        tick();
        n_checks++;
        if ({out_valid, out_last, busy, done} !== 4'b0000) begin
            n_errors++;
            $display("FAIL basic_idle got %b want 0000", {out_valid, out_last, busy, done});
        end
    endtask

    task automatic test_stall();
        int ei, ej, hs, cyc;
        logic r;
        ei = 0;
        ej = 0;
        hs = 0;
        cyc = 0;
        cfg_imax  = 10'd2;
        cfg_jmax  = 10'd1;
        out_ready = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        while (hs < 6 && cyc < 200) begin
            r = 1'($urandom_range(0, 1));
            out_ready = r;
            expv = {1'b1, 10'(ei), 10'(ej), (ei == 2 && ej == 1), 1'b1, 1'b0};
            n_checks++;
            if (obs !== expv) begin
                n_errors++;
                $display("FAIL stall_cyc%0d got %h want %h", cyc, obs, expv);
            end
            tick();
            cyc++;
            if (r) begin
                hs++;
                if (ei == 2) begin
                    ei = 0;
                    ej++;
                end else begin
                    ei++;
                end
            end
        end
        n_checks++;
        if (hs != 6) begin
            n_errors++;
            $display("FAIL stall_timeout handshakes %0d want 6", hs);
        end
        n_checks++;
        if ({out_valid, out_last, busy, done} !== 4'b0011) begin
            n_errors++;
            $display("FAIL stall_done got %b want 0011", {out_valid, out_last, busy, done});
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_single_restart();
        cfg_imax  = 10'd0;
        cfg_jmax  = 10'd0;
        out_ready = 1'b1;
        start     = 1'b1;
        for (int rep = 0; rep < 3; rep++) begin
            tick();
            expv = {1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0};
            n_checks++;
            if (obs !== expv) begin
                n_errors++;
                $display("FAIL single_pair%0d got %h want %h", rep, obs, expv);
            end
            tick();
            n_checks++;
            if ({out_valid, out_last, busy, done} !== 4'b0011) begin
                n_errors++;
                $display("FAIL single_done%0d got %b want 0011", rep,
                         {out_valid, out_last, busy, done});
            end
            tick();
            n_checks++;
            if ({out_valid, out_last, busy, done} !== 4'b0000) begin
                n_errors++;
                $display("FAIL single_idle%0d got %b want 0000", rep,
                         {out_valid, out_last, busy, done});
            end
        end
        start = 1'b0;
        tick();
        n_checks++;
        if ({out_valid, busy} !== 2'b00) begin
            n_errors++;
            $display("FAIL single_stop got %b want 00", {out_valid, busy});
        end
    endtask

    task automatic test_wide();
        cfg_imax4 = 4'd15;
        cfg_jmax4 = 4'd15;
        ready4    = 1'b1;
        start4    = 1'b1;
        tick();
        start4 = 1'b0;
        for (int k = 0; k < 256; k++) begin
            // Mid-sweep start and cfg changes must not disturb the sweep.
            if (k == 100) begin
                start4    = 1'b1;
                cfg_imax4 = 4'd3;
                cfg_jmax4 = 4'd2;
            end
            if (k == 101) start4 = 1'b0;
            expv4 = {1'b1, 4'(k % 16), 4'(k / 16), (k == 255), 1'b1, 1'b0};
            n_checks++;
            if (obs4 !== expv4) begin
                n_errors++;
                $display("FAIL wide_pair%0d got %h want %h", k, obs4, expv4);
            end
            tick();
        end
        n_checks++;
        if ({out_valid4, out_last4, busy4, done4} !== 4'b0011) begin
            n_errors++;
            $display("FAIL wide_done got %b want 0011", {out_valid4, out_last4, busy4, done4});
        end
        tick();
        n_checks++;
        if ({out_valid4, busy4, done4} !== 3'b000) begin
            n_errors++;
            $display("FAIL wide_idle got %b want 000", {out_valid4, busy4, done4});
        end
    endtask

    task automatic test_abort();
        cfg_imax  = 10'd3;
        cfg_jmax  = 10'd3;
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            expv = {1'b1, 10'(k), 10'd0, 1'b0, 1'b1, 1'b0};
            n_checks++;
            if (obs !== expv) begin
                n_errors++;
                $display("FAIL abort_pair%0d got %h want %h", k, obs, expv);
            end
            if (k == 2) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        n_checks++;
        if (obs !== 24'h0) begin
            n_errors++;
            $display("FAIL abort_idle got %h want %h", obs, 24'h0);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if ({done, busy} !== 2'b00) begin
                n_errors++;
                $display("FAIL abort_nodone%0d got %b want 00", c, {done, busy});
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        expv = {1'b1, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0};
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL abort_restart got %h want %h", obs, expv);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        cfg_imax  = 10'd2;
        cfg_jmax  = 10'd1;
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (obs !== 24'h0) begin
            n_errors++;
            $display("FAIL resetmid_clear got %h want %h", obs, 24'h0);
        end
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            expv = {1'b1, 10'(k % 3), 10'(k / 3), (k == 5), 1'b1, 1'b0};
            n_checks++;
            if (obs !== expv) begin
                n_errors++;
                $display("FAIL resetmid_pair%0d got %h want %h", k, obs, expv);
            end
            tick();
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_errors++;
            $display("FAIL resetmid_done got %b want 1", done);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        cfg_imax  = '0;
        cfg_jmax  = '0;
        start4    = 1'b0;
        abort4    = 1'b0;
        ready4    = 1'b0;
        cfg_imax4 = '0;
        cfg_jmax4 = '0;

        test_reset();
        test_basic();
        test_stall();
        test_single_restart();
        test_wide();
        test_abort();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
